disp_iq_router: RTL and testbench

- Receiving end of the integer dispatch interface. It consumes micro-ops offered by the integer dispatch queue (per-slot req/info) and returns per-slot rdy.
- It routes each accepted micro-op to its target issue queue using issueQueId, and registers the enqueue toward the issue queues.
- Per-IQ credit counters keep it from overfilling an issue queue.
- Sits between the dispatch stage and the integer issue queues (ALU/MDU/BRU/SCU).

---
 rtl/disp_iq_router_pkg.sv | 22 ++
 rtl/iq_credit_cnt.sv | 39 +++
 rtl/disp_iq_router.sv | 155 +++++++++++++++
 tb/tb_disp_iq_router.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_iq_router_pkg.sv
// Shared integer-dispatch definitions: IQ ids, micro-op payload and default sizes.
package disp_iq_router_pkg;

  localparam int unsigned INTDQ_DISP_WID  = 4;
  localparam int unsigned IQ_NUM_DEF      = 4;
  localparam int unsigned IQ_ENQ_WID_DEF  = 2;
  localparam int unsigned IQ_DEPTH_DEF    = 16;
  localparam int unsigned QID_W           = 3;

  localparam logic [QID_W-1:0] ALUIQ_ID = 3'd0;
  localparam logic [QID_W-1:0] MDUIQ_ID = 3'd1;
  localparam logic [QID_W-1:0] BRUIQ_ID = 3'd2;
  localparam logic [QID_W-1:0] SCUIQ_ID = 3'd3;

  typedef struct packed {
    logic [QID_W-1:0] issueQueId;
    logic [7:0]       opcode;
    logic [6:0]       pdst;
    logic [5:0]       rob_idx;
  } microOp_t;

endpackage

// File: rtl/iq_credit_cnt.sv
// Free-entry credit counter for one issue queue; saturates at IQ_DEPTH on over-release.
module iq_credit_cnt
  import disp_iq_router_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int unsigned CRD_W    = $clog2(IQ_DEPTH + 1),
  parameter int unsigned GNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             squash_i,
  input  logic [GNT_W-1:0] grant_i,
  input  logic [CRD_W-1:0] release_i,
  output logic [CRD_W-1:0] credit_o
);

  localparam int unsigned SUM_W = CRD_W + 1;

  logic [CRD_W-1:0] credit_q, credit_d;
  logic [SUM_W-1:0] sum;
  logic             overflow;

  // grant never exceeds current credit, so the subtraction cannot underflow
  always_comb begin
    sum      = SUM_W'(credit_q) - SUM_W'(grant_i) + SUM_W'(release_i);
    overflow = (sum > SUM_W'(IQ_DEPTH));
    credit_d = (squash_i || overflow) ? CRD_W'(IQ_DEPTH) : sum[CRD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_q <= CRD_W'(IQ_DEPTH);
    else        credit_q <= credit_d;
  end

  assign credit_o = credit_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) squash_i || !overflow);

endmodule

// File: rtl/disp_iq_router.sv
// Integer dispatch receiver: in-order credit-checked acceptance and routing into IQ enqueue lanes.
// Optional stall counters are built when DISP_IQ_ROUTER_PERF_EN is defined.
module disp_iq_router
  import disp_iq_router_pkg::*;
#(
  parameter int unsigned DISP_WID   = INTDQ_DISP_WID,
  parameter int unsigned IQ_NUM     = IQ_NUM_DEF,
  parameter int unsigned IQ_ENQ_WID = IQ_ENQ_WID_DEF,
  parameter int unsigned IQ_DEPTH   = IQ_DEPTH_DEF,
  parameter int unsigned CRD_W      = $clog2(IQ_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_squash_vld,
  input  logic [DISP_WID-1:0]          i_disp_req,
  input  microOp_t                     i_disp_info [DISP_WID],
  output logic [DISP_WID-1:0]          o_disp_rdy,
  input  logic [IQ_NUM*CRD_W-1:0]      i_iq_release,
  output logic [IQ_NUM*IQ_ENQ_WID-1:0] o_iq_enq_vld,
  output microOp_t                     o_iq_enq_info [IQ_NUM][IQ_ENQ_WID],
  output logic                         o_illegal_iq
`ifdef DISP_IQ_ROUTER_PERF_EN
  ,
  output logic [31:0]                  o_perf_crd_stall [IQ_NUM],
  output logic [31:0]                  o_perf_port_stall
`endif
);

  localparam int unsigned GNT_W  = $clog2(IQ_ENQ_WID + 1);
  localparam int unsigned IQ_W   = (IQ_NUM > 1) ? $clog2(IQ_NUM) : 1;
  localparam int unsigned LANE_W = (IQ_ENQ_WID > 1) ? $clog2(IQ_ENQ_WID) : 1;

  logic [CRD_W-1:0]      credit   [IQ_NUM];
  logic [GNT_W-1:0]      gnt_cnt  [IQ_NUM];
  logic [IQ_ENQ_WID-1:0] vld_d    [IQ_NUM];
  logic [IQ_ENQ_WID-1:0] vld_q    [IQ_NUM];
  microOp_t              info_d   [IQ_NUM][IQ_ENQ_WID];
  microOp_t              info_q   [IQ_NUM][IQ_ENQ_WID];
  logic                  illegal_d, illegal_q;
  logic [DISP_WID-1:0]   rdy_c;

  logic [QID_W-1:0]  qid;
  logic [IQ_W-1:0]   qi;
  logic [LANE_W-1:0] lane;
  logic              legal, has_crd, has_port, blocked, first_seen, accept_en;

`ifdef DISP_IQ_ROUTER_PERF_EN
  logic [IQ_NUM-1:0] blk_crd;
  logic              blk_port;
`endif

  // Oldest-first scan; the first refused slot blocks every younger one
  always_comb begin
    rdy_c      = '0;
    illegal_d  = 1'b0;
    blocked    = 1'b0;
    first_seen = 1'b0;
    qid        = '0;
    qi         = '0;
    lane       = '0;
    legal      = 1'b0;
    has_crd    = 1'b0;
    has_port   = 1'b0;
    accept_en  = rst_n && !i_squash_vld;
`ifdef DISP_IQ_ROUTER_PERF_EN
    blk_crd    = '0;
    blk_port   = 1'b0;
`endif
    for (int q = 0; q < IQ_NUM; q++) begin
      gnt_cnt[q] = '0;
      vld_d[q]   = '0;
      for (int n = 0; n < IQ_ENQ_WID; n++) info_d[q][n] = '0;
    end
    for (int k = 0; k < DISP_WID; k++) begin
      qid      = i_disp_info[k].issueQueId;
      qi       = qid[IQ_W-1:0];
      legal    = (qid < QID_W'(IQ_NUM));
      has_crd  = legal && (credit[qi] > CRD_W'(gnt_cnt[qi]));
      has_port = legal && (gnt_cnt[qi] < GNT_W'(IQ_ENQ_WID));
      lane     = gnt_cnt[qi][LANE_W-1:0];
      if (accept_en && i_disp_req[k] && !blocked && has_crd && has_port) begin
        rdy_c[k]           = 1'b1;
        vld_d[qi][lane]    = 1'b1;
        info_d[qi][lane]   = i_disp_info[k];
        gnt_cnt[qi]        = gnt_cnt[qi] + GNT_W'(1);
      end else begin
        blocked = 1'b1;
        if (i_disp_req[k] && !first_seen) begin
          first_seen = 1'b1;
          illegal_d  = accept_en && !legal;
`ifdef DISP_IQ_ROUTER_PERF_EN
          blk_crd[qi] = accept_en && legal && !has_crd;
          blk_port    = accept_en && has_crd && !has_port;
`endif
        end
      end
    end
  end

  assign o_disp_rdy = rdy_c;

  for (genvar q = 0; q < IQ_NUM; q++) begin : gen_iq
    iq_credit_cnt #(
      .IQ_DEPTH (IQ_DEPTH),
      .CRD_W    (CRD_W),
      .GNT_W    (GNT_W)
    ) u_crd (
      .clk       (clk),
      .rst_n     (rst_n),
      .squash_i  (i_squash_vld),
      .grant_i   (gnt_cnt[q]),
      .release_i (i_iq_release[q*CRD_W +: CRD_W]),
      .credit_o  (credit[q])
    );
    assign o_iq_enq_vld[q*IQ_ENQ_WID +: IQ_ENQ_WID] = vld_q[q];
  end

  // Squash needs no term here: the scan already produces an all-zero enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < IQ_NUM; q++) begin
        vld_q[q] <= '0;
        for (int n = 0; n < IQ_ENQ_WID; n++) info_q[q][n] <= '0;
      end
      illegal_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      info_q    <= info_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_iq_enq_info = info_q;
  assign o_illegal_iq  = illegal_q;

`ifdef DISP_IQ_ROUTER_PERF_EN
  logic [31:0] perf_crd_q [IQ_NUM];
  logic [31:0] perf_port_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < IQ_NUM; q++) perf_crd_q[q] <= '0;
      perf_port_q <= '0;
    end else begin
      for (int q = 0; q < IQ_NUM; q++)
        if (blk_crd[q]) perf_crd_q[q] <= perf_crd_q[q] + 32'd1;
      if (blk_port) perf_port_q <= perf_port_q + 32'd1;
    end
  end

  assign o_perf_crd_stall  = perf_crd_q;
  assign o_perf_port_stall = perf_port_q;
`endif

endmodule

// File: tb/tb_disp_iq_router.sv
// Randomised and directed bench for disp_iq_router against a queue-based acceptance model.
module tb_disp_iq_router;
  import disp_iq_router_pkg::*;

  localparam int DW  = 4;
  localparam int NQ  = 4;
  localparam int EW  = 2;
  localparam int DEP = 16;
  localparam int CW  = 5;

  logic              clk, rst_n, sq;
  logic [DW-1:0]     req, rdy;
  microOp_t          info [DW];
  logic [NQ*CW-1:0]  rel;
  logic [NQ*EW-1:0]  vld;
  microOp_t          enq  [NQ][EW];
  logic              ill;

  disp_iq_router #(
    .DISP_WID(DW), .IQ_NUM(NQ), .IQ_ENQ_WID(EW), .IQ_DEPTH(DEP), .CRD_W(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_squash_vld(sq),
    .i_disp_req(req), .i_disp_info(info), .o_disp_rdy(rdy),
    .i_iq_release(rel), .o_iq_enq_vld(vld), .o_iq_enq_info(enq),
    .o_illegal_iq(ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int       n_cmp, n_bad;
  int       crd [NQ];
  int       exp_n [NQ];
  microOp_t exp_enq [NQ][EW];
  logic [NQ*EW-1:0] exp_vld;
  logic     exp_ill;
  bit       auto_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [DW-1:0] r, input int i0, input int i1, input int i2, input int i3);
    int ids [DW];
    ids = '{i0, i1, i2, i3};
    req = r;
    for (int k = 0; k < DW; k++) begin
      info[k].issueQueId = 3'(ids[k]);
      info[k].opcode     = 8'($urandom);
      info[k].pdst       = 7'($urandom);
      info[k].rob_idx    = 6'($urandom);
    end
  endtask

  function automatic int rid();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(4, 7));
    return int'($urandom_range(0, 3));
  endfunction

  // One clock: model acceptance from queues, check rdy, then check registered outputs
  task automatic cycle(input logic s, input logic [NQ*CW-1:0] man_rel, output logic [DW-1:0] got_rdy);
    microOp_t      lq [NQ][$];
    logic [DW-1:0] m_rdy;
    logic          m_ill;
    bit            stop;
    int            fk, id, lim, r, maxr;
    m_rdy = '0;
    stop  = 0;
    fk    = -1;
    sq    = s;
    for (int k = 0; k < DW; k++) begin
      id  = int'(info[k].issueQueId);
      lim = 0;
      if (id < NQ) lim = (crd[id] < EW) ? crd[id] : EW;
      if (!stop && req[k] && id < NQ && lq[id].size() < lim) begin
        lq[id].push_back(info[k]);
        m_rdy[k] = 1'b1;
      end else begin
        stop = 1;
      end
    end
    for (int k = 0; k < DW; k++)
      if (fk < 0 && req[k] && !m_rdy[k]) fk = k;
    m_ill = (fk >= 0) && (int'(info[fk].issueQueId) >= NQ);
    if (s) begin
      m_rdy = '0;
      m_ill = 1'b0;
      for (int q = 0; q < NQ; q++) lq[q].delete();
    end
    for (int q = 0; q < NQ; q++) begin
      if (s) r = 0;
      else if (auto_rel) begin
        maxr = DEP - (crd[q] - lq[q].size());
        if (maxr > 4) maxr = 4;
        r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, maxr)) : 0;
      end else r = int'(man_rel[q*CW +: CW]);
      rel[q*CW +: CW] = CW'(r);
      crd[q] = s ? DEP : crd[q] - lq[q].size() + r;
      exp_n[q] = lq[q].size();
      for (int n = 0; n < lq[q].size(); n++) exp_enq[q][n] = lq[q][n];
    end
    exp_vld = '0;
    for (int q = 0; q < NQ; q++)
      for (int n = 0; n < exp_n[q]; n++) exp_vld[q*EW + n] = 1'b1;
    exp_ill = m_ill;
    #1;
    chk("rdy", 32'(rdy), 32'(m_rdy));
    got_rdy = rdy;
    @(posedge clk);
    #1;
    chk("enq_vld", 32'(vld), 32'(exp_vld));
    chk("illegal", 32'(ill), 32'(exp_ill));
    for (int q = 0; q < NQ; q++)
      for (int n = 0; n < exp_n[q]; n++)
        chk($sformatf("info_q%0d_l%0d", q, n), 32'(enq[q][n]), 32'(exp_enq[q][n]));
  endtask

  task automatic squash();
    logic [DW-1:0] r;
    set_ops('0, 0, 0, 0, 0);
    cycle(1'b1, '0, r);
  endtask

  // Drives all slots at IQ0 and expects two grants per cycle until 16 are used
  task automatic drain_iq0(input string tag, input int ncyc);
    logic [DW-1:0] r;
    for (int i = 0; i < ncyc; i++) begin
      set_ops('1, 0, 0, 0, 0);
      cycle(1'b0, '0, r);
      chk(tag, 32'(r), (i < 8) ? 32'h3 : 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]    r;
    logic [NQ*CW-1:0] mrel;
    microOp_t         s0, s1, s2, s3;
    n_cmp = 0; n_bad = 0; auto_rel = 0;
    rst_n = 1'b0; sq = 1'b0; rel = '0;
    set_ops('1, 0, 1, 2, 3);
    for (int q = 0; q < NQ; q++) crd[q] = DEP;
    #1;
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_ill", 32'(ill), 32'h0);
    chk("rst_info", 32'(enq[0][0]), 32'h0);
    req = '0;
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    drain_iq0("exh_rdy", 10);

    squash();
    set_ops('1, 0, 1, 0, 2);
    s0 = info[0]; s1 = info[1]; s2 = info[2]; s3 = info[3];
    cycle(1'b0, '0, r);
    chk("mix_rdy", 32'(r), 32'hf);
    chk("mix_vld", 32'(vld), 32'h17);
    chk("mix_iq0_l0", 32'(enq[0][0]), 32'(s0));
    chk("mix_iq0_l1", 32'(enq[0][1]), 32'(s2));
    chk("mix_iq1_l0", 32'(enq[1][0]), 32'(s1));
    chk("mix_iq2_l0", 32'(enq[2][0]), 32'(s3));

    squash();
    for (int i = 0; i < 8; i++) begin
      set_ops('1, 1, 1, 1, 1);
      cycle(1'b0, '0, r);
    end
    set_ops('1, 0, 1, 2, 0);
    mrel = '0;
    mrel[1*CW +: CW] = CW'(1);
    cycle(1'b0, mrel, r);
    chk("pfx_blk_rdy", 32'(r), 32'h1);
    set_ops('1, 0, 1, 2, 0);
    cycle(1'b0, '0, r);
    chk("pfx_rel_rdy", 32'(r), 32'hf);

    squash();
    set_ops('1, 0, 4, 1, 2);
    cycle(1'b0, '0, r);
    chk("ill_rdy", 32'(r), 32'h1);
    chk("ill_pulse", 32'(ill), 32'h1);
    set_ops('0, 0, 0, 0, 0);
    cycle(1'b0, '0, r);
    chk("ill_clear", 32'(ill), 32'h0);

    squash();
    for (int i = 0; i < 6; i++) begin
      set_ops('1, 0, 0, 0, 0);
      cycle(1'b0, '0, r);
    end
    set_ops(4'h1, 0, 0, 0, 0);
    cycle(1'b0, '0, r);
    set_ops('1, 0, 0, 0, 0);
    cycle(1'b1, '0, r);
    chk("sq_rdy", 32'(r), 32'h0);
    chk("sq_vld", 32'(vld), 32'h0);
    drain_iq0("sq_refill_rdy", 10);

    squash();
    auto_rel = 1;
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] rq;
      rq = ($urandom_range(0, 1) == 0) ? DW'($urandom) : DW'((1 << $urandom_range(0, DW)) - 1);
      set_ops(rq, rid(), rid(), rid(), rid());
      cycle(($urandom_range(0, 24) == 0), '0, r);
    end
    auto_rel = 0;

    set_ops('1, 0, 1, 2, 3);
    cycle(1'b0, '0, r);
    chk("prerst_vld_nz", 32'(vld != '0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_rdy", 32'(rdy), 32'h0);
    chk("arst_info", 32'(enq[0][0]), 32'h0);
    @(posedge clk); #1;
    chk("arst_hold_vld", 32'(vld), 32'h0);
    req = '0;
    rel = '0;
    #2 rst_n = 1'b1;
    for (int q = 0; q < NQ; q++) crd[q] = DEP;
    @(posedge clk); #1;
    drain_iq0("arst_refill_rdy", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
